dma_desc_scheduler: RTL and testbench
=====================================

// Module: dma_desc_scheduler
// PURPOSE
//  Shares one DMA engine between N_REQ requesters. Arbitrates descriptor requests round-robin and programs
//  the DMA CSR bank over an AXI4-Lite master port: SRC, DST, LEN, then GO. Waits for the DMA done/error IRQ,
//  then returns a completion status to the granted requester. Sits between requester logic and the DMA CSR slave port.
// PARAMETERS
//  N_REQ        4        number of requesters (2..8)
//  ADDR_W       32       AXI-Lite address / descriptor address width
//  DATA_W       32       AXI-Lite data width; LEN field width
//  CSR_BASE     'h0      base address of the DMA CSR bank
//  OFF_SRC/DST/LEN/GO  'h08/'h0C/'h10/'h00   CSR offsets; GO write data = 32'h1
//  TIMEOUT_CYC  65535    max cycles waiting for IRQ after GO is accepted; 0 disables the timeout
// PORTS
//  clk          in   1              clock
//  rst          in   1              asynchronous, active-low reset
//  req_valid_i  in   N_REQ          per-requester descriptor valid; held until ready
//  req_ready_o  out  N_REQ          one-hot, 1-cycle pulse; descriptor latched this cycle
//  req_src_i    in   N_REQ*ADDR_W   source address, requester i at [i*ADDR_W +: ADDR_W]
//  req_dst_i    in   N_REQ*ADDR_W   destination address, packed the same way
//  req_len_i    in   N_REQ*DATA_W   byte count, packed the same way
//  cpl_valid_o  out  N_REQ          one-hot, 1-cycle completion pulse
//  cpl_err_o    out  1              qualifies cpl_valid_o: 1 = bus error, DMA error or timeout
//  busy_o       out  1              high from grant until the completion pulse
//  m_awaddr/awprot/awvalid out ADDR_W/3/1; m_awready in 1    AXI-Lite write address; awprot = 3'b000
//  m_wdata/wstrb/wvalid    out DATA_W/DATA_W/8/1; m_wready in 1   AXI-Lite write data; wstrb all ones
//  m_bresp in 2; m_bvalid in 1; m_bready out 1               AXI-Lite write response
//  dma_done_i   in   1              DMA done IRQ, level or pulse; sampled only in WAIT
//  dma_error_i  in   1              DMA error IRQ, same rules as dma_done_i
// BEHAVIOUR
//  Reset: all outputs 0, FSM = IDLE, RR pointer = N_REQ-1 (requester 0 has first priority), descriptor regs 0.
//  Reset asserted mid-transfer: everything above is restored at once; the in-flight descriptor is dropped
//    and no completion pulse is issued.
//  FSM states: IDLE, WR_SRC, WR_DST, WR_LEN, WR_GO, WAIT, CPL.
//  IDLE
//    - If any req_valid_i: grant the first valid requester after the RR pointer (wrapping).
//    - Grant cycle: req_ready_o[g] = 1, latch src/dst/len and g, pointer <= g, busy_o <= 1, go to WR_SRC.
//    - Grant-to-first-awvalid latency: 1 cycle.
//  WR_x (write states)
//    - On entry, assert awvalid and wvalid together; awaddr = CSR_BASE + OFF_x; wdata = latched field.
//    - awvalid drops the cycle after awready; wvalid drops the cycle after wready. They complete independently.
//    - Address and data are never re-asserted once accepted.
//    - bready = 1 once both handshakes are done; hold until bvalid.
//    - bresp == OKAY: advance SRC->DST->LEN->GO->WAIT.
//    - bresp != OKAY: set err flag, skip remaining writes, go to CPL. GO is never issued after a failed write.
//    - aw/w/b signals stay stable while valid and not ready (AXI rule). Only one write is outstanding.
//  WAIT
//    - Timeout counter is cleared on entry and counts every cycle.
//    - dma_error_i: err = 1, go to CPL. dma_done_i alone: err = 0, go to CPL.
//    - Both high in the same cycle: error wins.
//    - Counter == TIMEOUT_CYC-1 with no IRQ: err = 1, go to CPL. IRQ arriving on the same cycle wins over the timeout.
//  CPL
//    - One cycle: cpl_valid_o[g] = 1, cpl_err_o = err, busy_o = 0; then IDLE.
//    - No new grant in this cycle, so back-to-back descriptors have 1 idle cycle between them.
//  General
//    - A requester deasserting req_valid_i before grant is legal; it simply loses arbitration.
//    - len == 0 is forwarded unchanged; the DMA decides how to handle it.
//  Arithmetic: CSR address = CSR_BASE + offset, modulo 2^ADDR_W. Timeout counter width = $clog2(TIMEOUT_CYC+1).
// TESTING
//  1. Req0 src='h1000 dst='h2000 len=64; slave ready always; done 10 cycles after GO
//     -> AW sequence 'h08,'h0C,'h10,'h00 with data 'h1000,'h2000,64,1; cpl_valid_o=4'b0001, cpl_err_o=0.
//  2. Req0..3 all valid continuously -> grant order 0,1,2,3,0; each completion pulse goes to the matching requester.
//  3. bresp=SLVERR on the DST write -> no LEN or GO write issued; cpl_err_o=1; next descriptor proceeds normally.
//  4. awready delayed 3 cycles, wready immediate -> wvalid drops after 1 cycle; awaddr/wdata stable throughout;
//     exactly one B handshake per write.
//  5. TIMEOUT_CYC=16 and no IRQ -> cpl_err_o=1 exactly 16 cycles after WAIT entry;
//     done and error asserted together -> cpl_err_o=1.
//  6. rst low during the WR_LEN wait-for-B -> all outputs 0 immediately, no completion;
//     after release, requester 0 is granted first.

Source files
------------

// File: rtl/dma_desc_scheduler_if.sv
// AXI4-Lite write-only channel set used by the descriptor scheduler to program the DMA CSR bank.
interface dma_desc_scheduler_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   awaddr;
    logic [2:0]          awprot;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  awready, wready, bresp, bvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/dma_desc_scheduler.sv
// Round-robin descriptor scheduler: grants one requester, writes SRC/DST/LEN/GO to the DMA CSRs,
// waits for the DMA IRQ (or timeout) and pulses a completion back to the granted requester.
module dma_desc_scheduler #(
    parameter int              N_REQ       = 4,
    parameter int              ADDR_W      = 32,
    parameter int              DATA_W      = 32,
    parameter logic [ADDR_W-1:0] CSR_BASE  = '0,
    parameter logic [ADDR_W-1:0] OFF_SRC   = ADDR_W'('h08),
    parameter logic [ADDR_W-1:0] OFF_DST   = ADDR_W'('h0C),
    parameter logic [ADDR_W-1:0] OFF_LEN   = ADDR_W'('h10),
    parameter logic [ADDR_W-1:0] OFF_GO    = ADDR_W'('h00),
    parameter int              TIMEOUT_CYC = 65535
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid_i,
    output logic [N_REQ-1:0]        req_ready_o,
    input  logic [N_REQ*ADDR_W-1:0] req_src_i,
    input  logic [N_REQ*ADDR_W-1:0] req_dst_i,
    input  logic [N_REQ*DATA_W-1:0] req_len_i,
    output logic [N_REQ-1:0]        cpl_valid_o,
    output logic                    cpl_err_o,
    output logic                    busy_o,
    dma_desc_scheduler_if.master    m,
    input  logic                    dma_done_i,
    input  logic                    dma_error_i
);
    localparam int PTR_W = $clog2(N_REQ);
    localparam int TO_W  = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WR_SRC = 3'd1;
    localparam logic [2:0] S_WR_DST = 3'd2;
    localparam logic [2:0] S_WR_LEN = 3'd3;
    localparam logic [2:0] S_WR_GO  = 3'd4;
    localparam logic [2:0] S_WAIT   = 3'd5;
    localparam logic [2:0] S_CPL    = 3'd6;

    logic [2:0]        state_q, state_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [PTR_W-1:0]  gnt_q, gnt_d;
    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [DATA_W-1:0] len_q, len_d;
    logic              err_q, err_d;
    logic              awvalid_q, awvalid_d;
    logic              wvalid_q, wvalid_d;
    logic              aw_done_q, aw_done_d;
    logic              w_done_q, w_done_d;
    logic              bready_q, bready_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;

    logic              gnt_found;
    logic [PTR_W-1:0]  gnt_idx;
    logic              start_wr;
    logic              in_wr;
    int                arb_idx;

    // Search starts just after the last winner, so the previous winner has lowest priority.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        arb_idx   = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            arb_idx = (int'(ptr_q) + k) % N_REQ;
            if (!gnt_found && req_valid_i[arb_idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = PTR_W'(arb_idx);
            end
        end
    end

    assign in_wr = (state_q == S_WR_SRC) || (state_q == S_WR_DST) ||
                   (state_q == S_WR_LEN) || (state_q == S_WR_GO);

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_d     = gnt_q;
        src_d     = src_q;
        dst_d     = dst_q;
        len_d     = len_q;
        err_d     = err_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        bready_d  = bready_q;
        to_cnt_d  = to_cnt_q;
        start_wr  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (gnt_found) begin
                    ptr_d    = gnt_idx;
                    gnt_d    = gnt_idx;
                    src_d    = req_src_i[gnt_idx*ADDR_W +: ADDR_W];
                    dst_d    = req_dst_i[gnt_idx*ADDR_W +: ADDR_W];
                    len_d    = req_len_i[gnt_idx*DATA_W +: DATA_W];
                    err_d    = 1'b0;
                    state_d  = S_WR_SRC;
                    start_wr = 1'b1;
                end
            end
            S_WR_SRC, S_WR_DST, S_WR_LEN, S_WR_GO: begin
                if (awvalid_q && m.awready) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (wvalid_q && m.wready) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                if (!bready_q && aw_done_d && w_done_d) begin
                    bready_d = 1'b1;
                end
                if (bready_q && m.bvalid) begin
                    bready_d = 1'b0;
                    if (m.bresp != 2'b00) begin
                        // A failed CSR write aborts the descriptor; GO must never follow it.
                        err_d   = 1'b1;
                        state_d = S_CPL;
                    end else if (state_q == S_WR_GO) begin
                        to_cnt_d = '0;
                        state_d  = S_WAIT;
                    end else begin
                        state_d  = state_q + 3'd1;
                        start_wr = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                to_cnt_d = to_cnt_q + 1'b1;
                if (dma_error_i) begin
                    err_d   = 1'b1;
                    state_d = S_CPL;
                end else if (dma_done_i) begin
                    err_d   = 1'b0;
                    state_d = S_CPL;
                end else if ((TIMEOUT_CYC != 0) && (to_cnt_q == TO_W'(TIMEOUT_CYC - 1))) begin
                    err_d   = 1'b1;
                    state_d = S_CPL;
                end
            end
            S_CPL: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (start_wr) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            ptr_q     <= PTR_W'(N_REQ - 1);
            gnt_q     <= '0;
            src_q     <= '0;
            dst_q     <= '0;
            len_q     <= '0;
            err_q     <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            bready_q  <= 1'b0;
            to_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt_q     <= gnt_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            len_q     <= len_d;
            err_q     <= err_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            bready_q  <= bready_d;
            to_cnt_q  <= to_cnt_d;
        end
    end

    // Address and data are functions of the state only, so they hold steady while a write stalls.
    always_comb begin
        m.awaddr = '0;
        m.wdata  = '0;
        case (state_q)
            S_WR_SRC: begin
                m.awaddr = CSR_BASE + OFF_SRC;
                m.wdata  = DATA_W'(src_q);
            end
            S_WR_DST: begin
                m.awaddr = CSR_BASE + OFF_DST;
                m.wdata  = DATA_W'(dst_q);
            end
            S_WR_LEN: begin
                m.awaddr = CSR_BASE + OFF_LEN;
                m.wdata  = len_q;
            end
            S_WR_GO: begin
                m.awaddr = CSR_BASE + OFF_GO;
                m.wdata  = DATA_W'(1);
            end
            default: begin
                m.awaddr = '0;
                m.wdata  = '0;
            end
        endcase
    end

    assign m.wstrb   = in_wr ? '1 : '0;
    assign m.awprot  = 3'b000;
    assign m.awvalid = awvalid_q;
    assign m.wvalid  = wvalid_q;
    assign m.bready  = bready_q;

    assign req_ready_o = (rst && (state_q == S_IDLE) && gnt_found) ? (N_REQ'(1) << gnt_idx) : '0;
    assign cpl_valid_o = (state_q == S_CPL) ? (N_REQ'(1) << gnt_q) : '0;
    assign cpl_err_o   = (state_q == S_CPL) && err_q;
    assign busy_o      = (state_q != S_IDLE) && (state_q != S_CPL);
endmodule

// File: tb/tb_dma_desc_scheduler.sv
// Directed bench for dma_desc_scheduler: AXI-Lite CSR slave model, DMA IRQ model, immediate-assert checks.
module tb_dma_desc_scheduler;
    logic         clk;
    logic         rst;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready_o;
    logic [127:0] req_src, req_dst, req_len;
    logic [3:0]   cpl_valid_o;
    logic         cpl_err_o, busy_o;
    logic         dma_done_i, dma_error_i;

    dma_desc_scheduler_if #(.ADDR_W(32), .DATA_W(32)) axi();

    dma_desc_scheduler #(.N_REQ(4), .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(16)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready_o),
        .req_src_i(req_src), .req_dst_i(req_dst), .req_len_i(req_len),
        .cpl_valid_o(cpl_valid_o), .cpl_err_o(cpl_err_o), .busy_o(busy_o),
        .m(axi),
        .dma_done_i(dma_done_i), .dma_error_i(dma_error_i)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [31:0] aw_log[$];
    logic [31:0] w_log[$];
    logic [3:0]  gnt_log[$];
    int          b_cnt = 0;
    int          cpl_cnt = 0;
    int          stab_err = 0;

    int          aw_delay = 0, w_delay = 0, aw_cnt = 0, w_cnt = 0;
    logic        err_en = 0, hold_en = 0;
    logic [31:0] err_addr = 0, hold_addr = 0, last_awaddr = 0;
    bit          aw_hs = 0, w_hs = 0, b_hs = 0;
    logic        prev_awvalid = 0, prev_awready = 0, prev_wvalid = 0, prev_wready = 0;
    logic [31:0] prev_awaddr = 0, prev_wdata = 0;

    int          irq_mode = 0, irq_delay = 10, wait_entry = 0;
    bit          irq_armed = 0, irq_clear = 0;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    // CSR slave, DMA IRQ source and handshake monitor, all acting mid-cycle
    initial begin
        axi.awready = 0; axi.wready = 0; axi.bvalid = 0; axi.bresp = 0;
        dma_done_i = 0; dma_error_i = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                axi.awready = 0; axi.wready = 0; axi.bvalid = 0; axi.bresp = 0;
                dma_done_i = 0; dma_error_i = 0;
                aw_cnt = 0; w_cnt = 0; aw_hs = 0; w_hs = 0; b_hs = 0;
                irq_armed = 0; irq_clear = 0;
                prev_awvalid = 0; prev_awready = 0; prev_wvalid = 0; prev_wready = 0;
            end else begin
                if (prev_awvalid && !prev_awready && !(axi.awvalid && axi.awaddr === prev_awaddr)) stab_err++;
                if (prev_wvalid && !prev_wready && !(axi.wvalid && axi.wdata === prev_wdata)) stab_err++;
                if (irq_clear) begin
                    dma_done_i = 0; dma_error_i = 0; irq_clear = 0;
                end
                if (irq_armed && cyc == wait_entry + irq_delay) begin
                    irq_armed = 0;
                    if (irq_mode == 0) begin
                        dma_done_i = 1; irq_clear = 1;
                    end else if (irq_mode == 2) begin
                        dma_done_i = 1; dma_error_i = 1; irq_clear = 1;
                    end
                end
                axi.awready = axi.awvalid && (aw_cnt >= aw_delay);
                if (axi.awvalid) aw_cnt++; else aw_cnt = 0;
                axi.wready = axi.wvalid && (w_cnt >= w_delay);
                if (axi.wvalid) w_cnt++; else w_cnt = 0;
                if (b_hs) begin
                    axi.bvalid = 0; axi.bresp = 0; b_hs = 0; aw_hs = 0; w_hs = 0;
                end else if (aw_hs && w_hs && !axi.bvalid && !(hold_en && last_awaddr == hold_addr)) begin
                    axi.bvalid = 1;
                    axi.bresp  = (err_en && last_awaddr == err_addr) ? 2'b10 : 2'b00;
                end
                if (axi.awvalid && axi.awready) begin
                    aw_log.push_back(axi.awaddr); last_awaddr = axi.awaddr; aw_hs = 1;
                end
                if (axi.wvalid && axi.wready) begin
                    w_log.push_back(axi.wdata); w_hs = 1;
                end
                if (axi.bvalid && axi.bready) begin
                    b_cnt++; b_hs = 1;
                    if (last_awaddr == 32'h0 && axi.bresp == 2'b00) begin
                        wait_entry = cyc + 1; irq_armed = 1;
                    end
                end
                if (req_ready_o != 0) gnt_log.push_back(req_ready_o);
                if (cpl_valid_o != 0) cpl_cnt++;
                prev_awvalid = axi.awvalid; prev_awready = axi.awready; prev_awaddr = axi.awaddr;
                prev_wvalid = axi.wvalid; prev_wready = axi.wready; prev_wdata = axi.wdata;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_cpl(input string tag, input int budget);
        int n;
        n = 0;
        while (cpl_valid_o == 4'b0 && n < budget) begin
            tick(1);
            n++;
        end
        check({tag, "_cpl_seen"}, {63'b0, cpl_valid_o != 4'b0}, 64'd1);
    endtask

    task automatic issue(input int r, input logic [31:0] src, input logic [31:0] dst, input logic [31:0] len);
        int n;
        req_src[r*32 +: 32] = src;
        req_dst[r*32 +: 32] = dst;
        req_len[r*32 +: 32] = len;
        req_valid[r] = 1'b1;
        #1;
        n = 0;
        while (!req_ready_o[r] && n < 100) begin
            tick(1);
            n++;
        end
        check($sformatf("grant_req%0d", r), {63'b0, req_ready_o[r]}, 64'd1);
        tick(1);
        req_valid[r] = 1'b0;
    endtask

    task automatic clear_logs();
        aw_log.delete(); w_log.delete(); gnt_log.delete();
        b_cnt = 0; stab_err = 0;
    endtask

    initial begin
        int n, c0;
        rst = 1; req_valid = 0; req_src = 0; req_dst = 0; req_len = 0;
        #3 rst = 0;
        tick(3);
        check("rst_busy", busy_o, 0);
        check("rst_awvalid", axi.awvalid, 0);
        check("rst_cpl", cpl_valid_o, 0);
        rst = 1;
        tick(1);
        check("idle_bready", axi.bready, 0);
        check("idle_awaddr", axi.awaddr, 0);

        // 1: single descriptor from requester 0
        clear_logs(); irq_mode = 0; irq_delay = 10;
        req_src[31:0] = 32'h1000; req_dst[31:0] = 32'h2000; req_len[31:0] = 32'd64;
        req_valid = 4'b0001;
        #1;
        check("t1_ready", req_ready_o, 4'b0001);
        tick(1);
        req_valid = 4'b0000;
        check("t1_awvalid", axi.awvalid, 1);
        check("t1_wvalid", axi.wvalid, 1);
        check("t1_awaddr", axi.awaddr, 32'h08);
        check("t1_wdata", axi.wdata, 32'h1000);
        check("t1_wstrb", axi.wstrb, 4'hF);
        check("t1_awprot", axi.awprot, 0);
        check("t1_busy", busy_o, 1);
        wait_cpl("t1", 100);
        check("t1_cpl", cpl_valid_o, 4'b0001);
        check("t1_err", cpl_err_o, 0);
        check("t1_busy_cpl", busy_o, 0);
        check("t1_aw_n", aw_log.size(), 4);
        check("t1_aw0", aw_log[0], 32'h08);
        check("t1_aw1", aw_log[1], 32'h0C);
        check("t1_aw2", aw_log[2], 32'h10);
        check("t1_aw3", aw_log[3], 32'h00);
        check("t1_w0", w_log[0], 32'h1000);
        check("t1_w1", w_log[1], 32'h2000);
        check("t1_w2", w_log[2], 32'd64);
        check("t1_w3", w_log[3], 32'd1);
        check("t1_b_n", b_cnt, 4);
        tick(1);
        check("t1_cpl_pulse", cpl_valid_o, 0);

        // 2: all four valid; pointer sits at 0 so order is 1,2,3,0,1
        clear_logs(); irq_delay = 2;
        for (int r = 0; r < 4; r++) begin
            req_src[r*32 +: 32] = 32'hA000 + 32'(r) * 32'h100;
            req_dst[r*32 +: 32] = 32'hB000 + 32'(r) * 32'h100;
            req_len[r*32 +: 32] = 32'(r + 1);
        end
        req_valid = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_cpl($sformatf("t2_%0d", i), 200);
            check($sformatf("t2_cpl%0d", i), cpl_valid_o, 4'b0001 << ((i + 1) % 4));
            check($sformatf("t2_err%0d", i), cpl_err_o, 0);
            tick(1);
            if (i == 3) begin
                tick(1);
                req_valid = 4'b0000;
            end
        end
        check("t2_gnt_n", gnt_log.size(), 5);
        check("t2_gnt0", gnt_log[0], 4'b0010);
        check("t2_gnt3", gnt_log[3], 4'b0001);
        check("t2_src_req3", w_log[8], 32'hA300);
        check("t2_len_req3", w_log[10], 32'd4);

        // 3: SLVERR on DST write aborts the descriptor
        clear_logs(); err_en = 1; err_addr = 32'h0C;
        issue(2, 32'h3000, 32'h4000, 32'd0);
        wait_cpl("t3", 100);
        check("t3_cpl", cpl_valid_o, 4'b0100);
        check("t3_err", cpl_err_o, 1);
        check("t3_aw_n", aw_log.size(), 2);
        check("t3_aw1", aw_log[1], 32'h0C);
        check("t3_b_n", b_cnt, 2);
        err_en = 0;
        tick(1);
        clear_logs();
        issue(3, 32'h3100, 32'h4100, 32'd0);
        wait_cpl("t3b", 100);
        check("t3b_cpl", cpl_valid_o, 4'b1000);
        check("t3b_err", cpl_err_o, 0);
        check("t3b_aw_n", aw_log.size(), 4);
        check("t3b_len0", w_log[2], 32'd0);
        tick(1);

        // 4: awready late by 3 cycles, wready immediate
        clear_logs(); aw_delay = 3;
        issue(1, 32'h5000, 32'h6000, 32'd8);
        tick(1);
        check("t4_wvalid_drop", axi.wvalid, 0);
        check("t4_awvalid_hold", axi.awvalid, 1);
        tick(2);
        check("t4_awvalid_late", axi.awvalid, 1);
        check("t4_awaddr_late", axi.awaddr, 32'h08);
        tick(1);
        check("t4_awvalid_drop", axi.awvalid, 0);
        check("t4_bready", axi.bready, 1);
        wait_cpl("t4", 200);
        check("t4_cpl", cpl_valid_o, 4'b0010);
        check("t4_stable", stab_err, 0);
        check("t4_b_n", b_cnt, 4);
        check("t4_w_n", w_log.size(), 4);
        aw_delay = 0;
        tick(1);

        // 5: no IRQ -> timeout; then done+error together
        clear_logs(); irq_mode = 1;
        issue(0, 32'h7000, 32'h8000, 32'd16);
        wait_cpl("t5", 100);
        check("t5_cpl", cpl_valid_o, 4'b0001);
        check("t5_err", cpl_err_o, 1);
        check("t5_tmo_cycles", cyc - wait_entry, 16);
        tick(1);
        irq_mode = 2; irq_delay = 3;
        issue(1, 32'h7100, 32'h8100, 32'd16);
        wait_cpl("t5b", 100);
        check("t5b_cpl", cpl_valid_o, 4'b0010);
        check("t5b_err", cpl_err_o, 1);
        tick(1);

        // 6: reset while waiting for the LEN write response
        clear_logs(); irq_mode = 0; irq_delay = 2; hold_en = 1; hold_addr = 32'h10;
        issue(0, 32'h9000, 32'h9100, 32'd4);
        n = 0;
        while (!(axi.bready && axi.awaddr == 32'h10) && n < 100) begin
            tick(1);
            n++;
        end
        check("t6_in_len_b", {63'b0, axi.bready && axi.awaddr == 32'h10}, 64'd1);
        tick(2);
        c0 = cpl_cnt;
        rst = 0;
        #1;
        check("t6_busy", busy_o, 0);
        check("t6_awvalid", axi.awvalid, 0);
        check("t6_wvalid", axi.wvalid, 0);
        check("t6_bready", axi.bready, 0);
        check("t6_awaddr", axi.awaddr, 0);
        check("t6_wdata", axi.wdata, 0);
        hold_en = 0;
        req_valid = 4'b1111;
        #1;
        check("t6_ready_in_rst", req_ready_o, 0);
        tick(3);
        check("t6_cpl", cpl_valid_o, 0);
        check("t6_no_cpl", cpl_cnt, c0);
        rst = 1;
        #1;
        check("t6_first_grant", req_ready_o, 4'b0001);
        tick(1);
        req_valid = 4'b0000;
        wait_cpl("t6b", 100);
        check("t6b_cpl", cpl_valid_o, 4'b0001);
        check("t6b_err", cpl_err_o, 0);
        tick(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
